// File: rtl/imem_loader_if.sv
// Byte-stream receive port and instruction-memory write port of the loader.
// The loader sits on the slave side; the host link / memory sit on the master side.
interface imem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a length-prefixed, checksummed byte stream
// and writes little-endian words into instruction memory while holding the core.
//
// state | meaning
// IDLE  | no load since reset
// LEN0  | waiting for length low byte
// LEN1  | waiting for length high byte, length checked on acceptance
// DATA  | receiving payload bytes, one memory write per four bytes
// CSUM  | waiting for checksum byte
// DONE  | last load completed, core released
// ERR   | last load aborted, core kept held
module imem_loader #(
  parameter int DEPTH   = 256,
  parameter int TIMEOUT = 1000000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [15:0]  words
);

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;

  localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);
  localparam bit          TMO_EN   = (TIMEOUT != 0);

  state_t      state;
  state_t      state_next;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [7:0]  csum;
  logic [1:0]  byte_idx;
  logic [15:0] word_idx;
  logic [23:0] lanes;
  logic [31:0] tmo_cnt;
  logic [15:0] hdr_len;
  logic        accept;
  logic        start_ok;
  logic        hdr_len_bad;
  logic        last_lane;
  logic        last_word;
  logic        tmo_hit;
  logic        hold_next;

  assign busy         = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CSUM);
  assign bus.rx_ready = busy;
  assign accept       = bus.rx_valid & busy;
  assign start_ok     = start & ((state == IDLE) || (state == DONE) || (state == ERR));
  assign hdr_len      = {bus.rx_data, len_lo};
  assign hdr_len_bad  = (hdr_len == 16'd0) || (32'(hdr_len) > DEPTH_W);
  assign last_lane    = (byte_idx == 2'd3);
  assign last_word    = (word_idx == len - 16'd1);
  assign tmo_hit      = TMO_EN && busy && !accept && (tmo_cnt == TMO_LAST);
  assign hold_next    = (state_next != IDLE) && (state_next != DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_next = LEN0;
      LEN0:            if (accept) state_next = LEN1;
      LEN1:            if (accept) state_next = hdr_len_bad ? ERR : DATA;
      DATA:            if (accept && last_lane && last_word) state_next = CSUM;
      CSUM:            if (accept) state_next = (bus.rx_data == csum) ? DONE : ERR;
      default:         state_next = IDLE;
    endcase
    if (tmo_hit) state_next = ERR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      cpu_hold       <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      words          <= '0;
      len_lo         <= '0;
      len            <= '0;
      csum           <= '0;
      byte_idx       <= '0;
      word_idx       <= '0;
      lanes          <= '0;
      tmo_cnt        <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      cpu_hold    <= hold_next;
      if (start_ok) begin
        done     <= 1'b0;
        error    <= 1'b0;
        words    <= '0;
        csum     <= '0;
        byte_idx <= '0;
        word_idx <= '0;
        tmo_cnt  <= '0;
      end else begin
        if (busy) tmo_cnt <= accept ? '0 : tmo_cnt + 32'd1;
        if (accept && state == LEN0) len_lo <= bus.rx_data;
        if (accept && state == LEN1) len <= hdr_len;
        if (accept && state == DATA) begin
          csum     <= csum + bus.rx_data;
          byte_idx <= byte_idx + 2'd1;
          case (byte_idx)
            2'd0:    lanes[7:0]   <= bus.rx_data;
            2'd1:    lanes[15:8]  <= bus.rx_data;
            2'd2:    lanes[23:16] <= bus.rx_data;
            default: ;
          endcase
          // Lane 3 goes straight into the write word; never write past the memory.
          if (last_lane && (32'(word_idx) < DEPTH_W)) begin
            bus.imem_we    <= 1'b1;
            bus.imem_addr  <= {14'd0, word_idx, 2'b00};
            bus.imem_wdata <= {bus.rx_data, lanes};
            word_idx       <= word_idx + 16'd1;
            words          <= words + 16'd1;
          end
        end
        if (state == CSUM && state_next == DONE) done <= 1'b1;
        if (state != ERR && state_next == ERR) error <= 1'b1;
      end
    end
  end

endmodule
